// File: rtl/fsm_seq.sv
// fsm_seq: run-time-programmable step sequencer with dwell, skip, hold and per-step output patterns.
// Optional hold-timeout abort is enabled by defining FSM_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps

module fsm_seq #(
    parameter int NSTEPS   = 4,
    parameter int OUT_W    = 3,
    parameter int CNT_W    = 8,
    parameter int HOLD_MAX = 255,
    localparam int SW      = $clog2(NSTEPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             skip,
    input  logic             hold,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_addr,
    input  logic [OUT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_dwell,
    output logic [OUT_W-1:0] zot,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEPS - 1);

    logic [SW-1:0]    step, step_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done_nxt, timeout_nxt;
    logic             active, terminal, hold_abort, cfg_valid;

    logic [OUT_W-1:0] pattern [NSTEPS];
    logic [CNT_W-1:0] dwell   [NSTEPS];

    // Non-power-of-two step counts leave addresses with no backing entry.
    assign cfg_valid = 32'(cfg_addr) < 32'(NSTEPS);
    assign active    = (step != '0);
    // >= so that lowering dwell below the running count ends the step at once.
    assign terminal  = (cnt >= dwell[step]);

    // NOTE: the configuration table is cleared by reset because a mid-run reset must leave
    // the sequencer deprogrammed; a table that needn't be cleared would skip the reset term.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSTEPS; i++) begin
                pattern[i] <= '0;
                dwell[i]   <= '0;
            end
        end else if (cfg_we && cfg_valid) begin
            pattern[cfg_addr] <= cfg_pattern;
            dwell[cfg_addr]   <= cfg_dwell;
        end
    end

`ifdef FSM_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             holding;

    assign holding    = active && terminal && hold;
    assign hold_abort = holding && (hold_cnt >= CNT_W'(HOLD_MAX));

    always_comb begin
        hold_cnt_nxt = '0;
        if (holding && !hold_abort) begin
            hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
        end
    end
`else
    // No hold limit in this build: hold may stall a step forever.
    assign hold_abort = (HOLD_MAX < 0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step    <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            step    <= step_nxt;
            cnt     <= cnt_nxt;
            done    <= done_nxt;
            timeout <= timeout_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        step_nxt    = step;
        cnt_nxt     = cnt;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;

        if (!active) begin
            cnt_nxt = '0;
            if (start) begin
                step_nxt = SW'(1);
            end
        end else if (hold_abort) begin
            step_nxt    = '0;
            cnt_nxt     = '0;
            timeout_nxt = 1'b1;
        end else if (!terminal) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (hold) begin
            cnt_nxt = cnt;
        end else if (skip || step == LAST_STEP) begin
            step_nxt = '0;
            cnt_nxt  = '0;
            done_nxt = 1'b1;
        end else begin
            step_nxt = step + SW'(1);
            cnt_nxt  = '0;
        end
    end

    always_comb begin
        zot  = pattern[step];
        busy = active;
    end

endmodule

// File: tb/tb_fsm_seq.sv
// Scoreboard bench for fsm_seq: stimulus queues per-cycle expected outputs, a negedge monitor compares.
// Works with or without FSM_SEQ_TIMEOUT_EN defined.
`timescale 1ns/1ps

module tb_fsm_seq;

    localparam int NSTEPS   = 4;
    localparam int OUT_W    = 3;
    localparam int CNT_W    = 8;
    localparam int HOLD_MAX = 4;
    localparam int SW       = $clog2(NSTEPS);
`ifdef FSM_SEQ_TIMEOUT_EN
    localparam int HOLD_N   = 4;
`else
    localparam int HOLD_N   = 5;
`endif

    logic             clk;
    logic             reset;
    logic             start, skip, hold;
    logic             cfg_we;
    logic [SW-1:0]    cfg_addr;
    logic [OUT_W-1:0] cfg_pattern;
    logic [CNT_W-1:0] cfg_dwell;
    logic [OUT_W-1:0] zot;
    logic             busy, done, timeout;

    fsm_seq #(
        .NSTEPS(NSTEPS), .OUT_W(OUT_W), .CNT_W(CNT_W), .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .skip(skip), .hold(hold),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_pattern(cfg_pattern), .cfg_dwell(cfg_dwell),
        .zot(zot), .busy(busy), .done(done), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] zot;
        logic             busy;
        logic             done;
        logic             timeout;
        string            name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [OUT_W+2:0] got, input logic [OUT_W+2:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got {zot,busy,done,timeout}=%b, expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: one expected entry per checked cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check(mon_e.name, {zot, busy, done, timeout},
                  {mon_e.zot, mon_e.busy, mon_e.done, mon_e.timeout});
        end
    end

    task automatic push_now(input logic [OUT_W-1:0] z, input logic b, input logic d,
                            input logic t, input string name);
        exp_t e;
        e.zot = z; e.busy = b; e.done = d; e.timeout = t; e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_cyc(input logic [OUT_W-1:0] z, input logic b, input logic d,
                              input logic t, input string name);
        @(posedge clk);
        #1;
        push_now(z, b, d, t, name);
    endtask

    task automatic drive(input logic s, input logic k, input logic h);
        start = s;
        skip  = k;
        hold  = h;
    endtask

    task automatic cfg_set(input logic we, input logic [SW-1:0] a,
                           input logic [OUT_W-1:0] p, input logic [CNT_W-1:0] d);
        cfg_we = we; cfg_addr = a; cfg_pattern = p; cfg_dwell = d;
    endtask

    task automatic cfg_write(input logic [SW-1:0] a, input logic [OUT_W-1:0] p,
                             input logic [CNT_W-1:0] d);
        cfg_set(1'b1, a, p, d);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        cfg_set(1'b0, '0, '0, '0);

        // Reset state before and across a clock edge.
        #2;
        push_now(3'b000, 1'b0, 1'b0, 1'b0, "reset_async");
        expect_cyc(3'b000, 1'b0, 1'b0, 1'b0, "reset_held");
        reset = 1'b0;

        // Legacy profile: patterns 000,101,111,001, all dwell 0.
        cfg_write(2'd0, 3'b000, 8'd0);
        cfg_write(2'd1, 3'b101, 8'd0);
        cfg_write(2'd2, 3'b111, 8'd0);
        cfg_write(2'd3, 3'b001, 8'd0);

        drive(1'b1, 1'b0, 1'b0);
        expect_cyc(3'b101, 1'b1, 1'b0, 1'b0, "legacy_s1");
        expect_cyc(3'b111, 1'b1, 1'b0, 1'b0, "legacy_s2_start_ignored");
        drive(1'b0, 1'b0, 1'b0);
        expect_cyc(3'b001, 1'b1, 1'b0, 1'b0, "legacy_s3");
        expect_cyc(3'b000, 1'b0, 1'b1, 1'b0, "legacy_done");
        // start during the done cycle relaunches back-to-back.
        drive(1'b1, 1'b0, 1'b0);
        expect_cyc(3'b101, 1'b1, 1'b0, 1'b0, "b2b_relaunch");
        drive(1'b0, 1'b0, 1'b0);
        expect_cyc(3'b111, 1'b1, 1'b0, 1'b0, "b2b_s2");
        expect_cyc(3'b001, 1'b1, 1'b0, 1'b0, "b2b_s3");
        expect_cyc(3'b000, 1'b0, 1'b1, 1'b0, "b2b_done");
        expect_cyc(3'b000, 1'b0, 1'b0, 1'b0, "b2b_idle");

        // Skip in step 2 returns to idle without entering step 3.
        drive(1'b1, 1'b0, 1'b0);
        expect_cyc(3'b101, 1'b1, 1'b0, 1'b0, "skip_s1");
        drive(1'b0, 1'b0, 1'b0);
        expect_cyc(3'b111, 1'b1, 1'b0, 1'b0, "skip_s2");
        drive(1'b0, 1'b1, 1'b0);
        expect_cyc(3'b000, 1'b0, 1'b1, 1'b0, "skip_done");
        drive(1'b0, 1'b0, 1'b0);
        expect_cyc(3'b000, 1'b0, 1'b0, 1'b0, "skip_idle");

        // Dwell 2 in step 3, skip ignored before terminal count, then hold.
        cfg_write(2'd3, 3'b001, 8'd2);
        drive(1'b1, 1'b0, 1'b0);
        expect_cyc(3'b101, 1'b1, 1'b0, 1'b0, "dw_s1");
        drive(1'b0, 1'b0, 1'b0);
        expect_cyc(3'b111, 1'b1, 1'b0, 1'b0, "dw_s2");
        expect_cyc(3'b001, 1'b1, 1'b0, 1'b0, "dw_c0");
        drive(1'b0, 1'b1, 1'b0);
        expect_cyc(3'b001, 1'b1, 1'b0, 1'b0, "dw_c1_skip_ignored");
        drive(1'b0, 1'b0, 1'b1);
        expect_cyc(3'b001, 1'b1, 1'b0, 1'b0, "dw_c2_terminal");
        for (int i = 0; i < HOLD_N; i++) begin
            expect_cyc(3'b001, 1'b1, 1'b0, 1'b0, "hold_stay");
        end
        drive(1'b0, 1'b0, 1'b0);
        expect_cyc(3'b000, 1'b0, 1'b1, 1'b0, "hold_done");
        expect_cyc(3'b000, 1'b0, 1'b0, 1'b0, "hold_idle");

        // hold stuck high with skip also high in step 1 (dwell 0).
        drive(1'b1, 1'b0, 1'b0);
        expect_cyc(3'b101, 1'b1, 1'b0, 1'b0, "to_s1");
        drive(1'b0, 1'b1, 1'b1);
`ifdef FSM_SEQ_TIMEOUT_EN
        for (int i = 0; i < HOLD_MAX; i++) begin
            expect_cyc(3'b101, 1'b1, 1'b0, 1'b0, "to_held");
        end
        expect_cyc(3'b000, 1'b0, 1'b0, 1'b1, "timeout_pulse");
        drive(1'b0, 1'b0, 1'b0);
        expect_cyc(3'b000, 1'b0, 1'b0, 1'b0, "timeout_clear");
`else
        for (int i = 0; i < 1000; i++) begin
            expect_cyc(3'b101, 1'b1, 1'b0, 1'b0, "hold_stall");
        end
        drive(1'b0, 1'b1, 1'b0);
        expect_cyc(3'b000, 1'b0, 1'b1, 1'b0, "stall_release_done");
        drive(1'b0, 1'b0, 1'b0);
        expect_cyc(3'b000, 1'b0, 1'b0, 1'b0, "stall_idle");
`endif

        // Lower dwell[2] to 0 once cnt reaches 3; live pattern rewrite of step 3.
        cfg_write(2'd2, 3'b111, 8'd5);
        drive(1'b1, 1'b0, 1'b0);
        expect_cyc(3'b101, 1'b1, 1'b0, 1'b0, "cfg_s1");
        drive(1'b0, 1'b0, 1'b0);
        expect_cyc(3'b111, 1'b1, 1'b0, 1'b0, "cfg_s2_c0");
        expect_cyc(3'b111, 1'b1, 1'b0, 1'b0, "cfg_s2_c1");
        expect_cyc(3'b111, 1'b1, 1'b0, 1'b0, "cfg_s2_c2");
        cfg_set(1'b1, 2'd2, 3'b111, 8'd0);
        expect_cyc(3'b111, 1'b1, 1'b0, 1'b0, "cfg_s2_c3");
        cfg_we = 1'b0;
        expect_cyc(3'b001, 1'b1, 1'b0, 1'b0, "cfg_lowered_dwell_adv");
        cfg_set(1'b1, 2'd3, 3'b110, 8'd2);
        expect_cyc(3'b110, 1'b1, 1'b0, 1'b0, "cfg_live_pattern");
        cfg_we = 1'b0;
        expect_cyc(3'b110, 1'b1, 1'b0, 1'b0, "cfg_live_c2");
        expect_cyc(3'b000, 1'b0, 1'b1, 1'b0, "cfg_done");
        expect_cyc(3'b000, 1'b0, 1'b0, 1'b0, "cfg_idle");

        // Reset in step 2: immediate idle, no done, configuration cleared.
        drive(1'b1, 1'b0, 1'b0);
        expect_cyc(3'b101, 1'b1, 1'b0, 1'b0, "rst_s1");
        drive(1'b0, 1'b0, 1'b0);
        expect_cyc(3'b111, 1'b1, 1'b0, 1'b0, "rst_s2");
        @(negedge clk);
        #1;
        reset = 1'b1;
        push_now(3'b000, 1'b0, 1'b0, 1'b0, "reset_mid_run");
        @(negedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        expect_cyc(3'b000, 1'b1, 1'b0, 1'b0, "post_reset_s1");
        drive(1'b0, 1'b0, 1'b0);
        expect_cyc(3'b000, 1'b1, 1'b0, 1'b0, "post_reset_s2");
        expect_cyc(3'b000, 1'b1, 1'b0, 1'b0, "post_reset_s3");
        expect_cyc(3'b000, 1'b0, 1'b1, 1'b0, "post_reset_done");
        expect_cyc(3'b000, 1'b0, 1'b0, 1'b0, "post_reset_idle");

        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d queued expectations never compared", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
